// File: rtl/pwm_pkg.sv
// Shared types for the shadowed PWM block: carrier mode, count direction, prescaler sizing.
// Pure declarations; no logic, no latency, no flow control.
package pwm_pkg;

    typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTRE = 1'b1} pwm_mode_e;
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} pwm_dir_e;

    // A prescale of 1 still needs a one-bit counter so the declaration stays legal.
    function automatic int presc_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/pwm_shadowed_tick_gen.sv
// Prescaler: one-cycle tick every PRESCALE enabled clocks, combinational from the counter register.
// No handshake; the count is held at 0 while enable is low.
module tick_gen
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int PW = presc_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("tick_gen: PRESCALE must be >= 1");
    end

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    always_comb begin
        tick    = enable && (presc_q == LAST);
        presc_d = presc_q;
        if (!enable || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/pwm_shadowed.sv
// PWM generator with a one-entry duty shadow committed only at carrier wrap (or at once while disabled).
// pwm_out/period_start are registered (1 clk); duty_ready drops for as long as the shadow holds a code.
module pwm_shadowed
    import pwm_pkg::*;
#(
    parameter int        WIDTH    = 8,
    parameter int        PRESCALE = 1,
    parameter pwm_mode_e MODE     = PWM_EDGE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] duty_cycle,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic [WIDTH-1:0] duty_active,
    output logic             period_start,
    output logic             pwm_out
);

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic tick;

    tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    logic [WIDTH-1:0] count_q,  count_d;
    pwm_dir_e         dir_q,    dir_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             shadow_full_q, shadow_full_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             period_start_q, period_start_d;
    logic             pwm_q, pwm_d;
    logic             wrap;
    logic             accept;
    logic             commit;

    // Carrier: the centre carrier turns around on the tick that lands on MAX and wraps from 1 to 0.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        wrap    = 1'b0;
        if (!enable) begin
            count_d = '0;
            dir_d   = DIR_UP;
        end else if (tick) begin
            if (MODE == PWM_EDGE) begin
                count_d = count_q + ONE;
                wrap    = (count_q == MAX);
            end else if (dir_q == DIR_UP) begin
                count_d = count_q + ONE;
                if (count_q == MAX - ONE) begin
                    dir_d = DIR_DOWN;
                end
            end else begin
                count_d = count_q - ONE;
                if (count_q == ONE) begin
                    wrap  = 1'b1;
                    dir_d = DIR_UP;
                end
            end
        end
    end

    // Accept needs an empty shadow and commit needs a full one, so they never collide.
    always_comb begin
        accept        = duty_valid && !shadow_full_q;
        commit        = shadow_full_q && (wrap || !enable);
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        active_d      = active_q;
        if (commit) begin
            active_d      = shadow_q;
            shadow_full_d = 1'b0;
        end
        if (accept) begin
            shadow_d      = duty_cycle;
            shadow_full_d = 1'b1;
        end
    end

    always_comb begin
        period_start_d = wrap;
        pwm_d          = enable && (count_q < active_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q        <= '0;
            dir_q          <= DIR_UP;
            shadow_q       <= '0;
            shadow_full_q  <= 1'b0;
            active_q       <= '0;
            period_start_q <= 1'b0;
            pwm_q          <= 1'b0;
        end else begin
            count_q        <= count_d;
            dir_q          <= dir_d;
            shadow_q       <= shadow_d;
            shadow_full_q  <= shadow_full_d;
            active_q       <= active_d;
            period_start_q <= period_start_d;
            pwm_q          <= pwm_d;
        end
    end

    assign duty_ready   = !shadow_full_q;
    assign duty_active  = active_q;
    assign period_start = period_start_q;
    assign pwm_out      = pwm_q;

endmodule
